int_to_fp: RTL and testbench
============================

# int_to_fp

Sequential converter from a signed 32-bit two's-complement integer to the team's 32-bit floating-point format: 1 sign bit, 7-bit exponent with bias 63, and 24-bit fraction with a hidden bit. It produces the operands the FPU consumes, and its result is bit-compatible with FPU `data_out`/`status_out`. It uses a start/done handshake. Normalization is iterative, one bit per cycle, and rounding is round-to-nearest-even.

## Interface
Parameters: none. Format constants come from the shared package.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a conversion. Sampled only in IDLE.
- `int_in` in 32: signed operand. Sampled on the edge that accepts `start`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse, high in READY.
- `data_out` out 32: result `{sign, exp[6:0], frac[23:0]}`. Holds its value until the next result is written.
- `status_out` out 4: one-hot status. bit0 EXACT, bit1 OVERFLOW, bit2 UNDERFLOW, bit3 INEXACT. Holds its value like `data_out`.

## Operation
- States: IDLE, ABS, NORM, ROUND, READY.
- IDLE: when `start`=1, latch `int_in` and go to ABS. `start` in any other state is ignored.
- ABS:
  - Set `sign` = int_in[31] and `mag` = |int_in| as 32-bit unsigned; −2^31 gives 0x80000000.
  - Set `exp` = 94 (63+31).
  - If `mag`=0: write `data_out`=0x00000000 and `status_out`=0001, then go to READY.
  - Otherwise go to NORM.
- NORM, evaluated each cycle:
  - If mag[31]=0: `mag` <<= 1 and `exp` −= 1.
  - Otherwise go to ROUND.
  - Exactly k = 31−p shifts occur, where p is the index of the leading one.
- ROUND:
  - `frac` = mag[30:7], guard = mag[6], sticky = |mag[5:0].
  - Round up when guard & (sticky | frac[0]).
  - On round-up carry out of `frac` (all ones): `frac` = 0 and `exp` += 1.
  - Write `data_out` = {sign, exp, frac}.
  - `status_out` = 1000 if (guard | sticky), else 0001.
  - Go to READY.
- READY: `done`=1, then go to IDLE.
- Range: the exponent is always in 63..94, so OVERFLOW and UNDERFLOW are never raised. Those bits exist for format compatibility only.
- Width rule: `exp` is a 7-bit register; the +1 from rounding never exceeds 94.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `data_out`=0x00000000, `status_out`=0000, all internal registers 0.
- Latency, measured from the edge that samples `start` to the first cycle with `done`=1:
  - Nonzero input: k+3 cycles. Range is 3 cycles (|x|=2^31) to 34 cycles (|x|=1).
  - Zero input: 1 cycle.
- `data_out`/`status_out` update on the same edge that enters READY, so they are valid while `done`=1.
- Back-to-back: `start` may be asserted in the cycle `done`=1. It is not accepted until the following cycle, in IDLE.
- `reset` low mid-conversion: immediate return to reset values; no `done` is produced for the aborted operation.

## Structure
- Shared package `fp_pkg`:
  - FP_EXP_W=7, FP_FRAC_W=24, FP_BIAS=63.
  - Status bit indices ST_EXACT=0, ST_OVERFLOW=1, ST_UNDERFLOW=2, ST_INEXACT=3.
  - State typedef for this block.
- Sub-module `fp_round`: combinational round-to-nearest-even.
  - Inputs: 24-bit fraction, guard, sticky.
  - Outputs: rounded fraction, carry, inexact.
  - Reused later by the FPU ARRED stage.

## Test plan
- `int_in`=0x00000001 → `data_out`=0x3F000000, `status_out`=0001, `done` 34 cycles after start. `int_in`=0xFFFFFFFF → 0xBF000000, 0001.
- `int_in`=0x00000003 → 0x40800000, 0001, latency 33. `int_in`=0x80000000 → 0xDE000000, 0001, latency 3.
- `int_in`=0x7FFFFFFF → rounding carry → 0x5E000000, `status_out`=1000.
- Ties: 0x02000001 → 0x58000000, 1000 (tie rounds to even). 0x02000003 → 0x58000002, 1000.
- `int_in`=0 → 0x00000000, 0001, `done` 1 cycle after start.
- Protocol checks:
  - Pulse `start` while `busy` with a different `int_in`: it is ignored, and the result matches the first operand.
  - Drop `reset` during NORM: all outputs return to 0 and no `done` occurs.
  - Issue a new `start` in the `done` cycle: it is accepted one cycle later.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, types and packing helpers for the team floating-point format.
// Format: {sign, exp[6:0] (bias 63), frac[23:0] with hidden bit}.
package fp_pkg;

  localparam int FP_WIDTH  = 32;
  localparam int FP_EXP_W  = 7;
  localparam int FP_FRAC_W = 24;
  localparam int FP_BIAS   = 63;
  localparam int INT_W     = 32;

  // Exponent of a value whose leading one sits in bit INT_W-1.
  localparam logic [FP_EXP_W-1:0] EXP_MAX = 7'(FP_BIAS + INT_W - 1);

  localparam int ST_EXACT     = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_INEXACT   = 3;

  typedef enum logic [2:0] {
    I2F_IDLE  = 3'd0,
    I2F_ABS   = 3'd1,
    I2F_NORM  = 3'd2,
    I2F_ROUND = 3'd3,
    I2F_READY = 3'd4
  } i2f_state_t;

  function automatic logic [FP_WIDTH-1:0] fp_pack(
    input logic                 sign,
    input logic [FP_EXP_W-1:0]  exp,
    input logic [FP_FRAC_W-1:0] frac
  );
    fp_pack = {sign, exp, frac};
  endfunction

  // One-hot status word; overflow/underflow cannot occur for 32-bit integers.
  function automatic logic [3:0] status_word(input logic inexact);
    logic [3:0] st;
    st               = 4'b0000;
    st[ST_EXACT]     = ~inexact;
    st[ST_OVERFLOW]  = 1'b0;
    st[ST_UNDERFLOW] = 1'b0;
    st[ST_INEXACT]   = inexact;
    status_word = st;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational round-to-nearest-even on a 24-bit fraction with guard/sticky.
// A carry out means the fraction wrapped to zero and the exponent must step up.
module fp_round
  import fp_pkg::*;
(
  input  logic [FP_FRAC_W-1:0] frac,
  input  logic                 guard,
  input  logic                 sticky,
  output logic [FP_FRAC_W-1:0] frac_rnd,
  output logic                 carry,
  output logic                 inexact
);

  logic                 round_up;
  logic [FP_FRAC_W:0]   sum;

  // Ties go to the even fraction: only round up on a tie when frac is odd.
  always_comb begin
    round_up = guard & (sticky | frac[0]);
    sum      = {1'b0, frac} + {{FP_FRAC_W{1'b0}}, round_up};
    frac_rnd = sum[FP_FRAC_W-1:0];
    carry    = sum[FP_FRAC_W];
    inexact  = guard | sticky;
  end

endmodule

// File: rtl/int_to_fp.sv
// Iterative signed 32-bit integer to team float converter with start/done handshake.
// Normalises one bit per cycle, then rounds to nearest even.
module int_to_fp
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [INT_W-1:0]    int_in,
  output logic                busy,
  output logic                done,
  output logic [FP_WIDTH-1:0] data_out,
  output logic [3:0]          status_out
);

  i2f_state_t           state;
  logic [INT_W-1:0]     operand;
  logic [INT_W-1:0]     mag;
  logic [INT_W-1:0]     mag_abs;
  logic                 sign;
  logic [FP_EXP_W-1:0]  exp;

  logic [FP_FRAC_W-1:0] frac_rnd;
  logic                 carry;
  logic                 inexact;

  // Magnitude of the latched operand; -2^31 maps onto 0x80000000 unchanged.
  always_comb begin
    if (operand[INT_W-1]) begin
      mag_abs = ~operand + 32'd1;
    end else begin
      mag_abs = operand;
    end
  end

  fp_round u_round (
    .frac     (mag[INT_W-2 -: FP_FRAC_W]),
    .guard    (mag[6]),
    .sticky   (|mag[5:0]),
    .frac_rnd (frac_rnd),
    .carry    (carry),
    .inexact  (inexact)
  );

  // Control FSM plus datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= I2F_IDLE;
      operand    <= 32'd0;
      mag        <= 32'd0;
      sign       <= 1'b0;
      exp        <= 7'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= 32'd0;
      status_out <= 4'b0000;
    end else begin
      case (state)
        I2F_IDLE: begin
          done <= 1'b0;
          if (start) begin
            operand <= int_in;
            busy    <= 1'b1;
            state   <= I2F_ABS;
          end else begin
            busy    <= 1'b0;
          end
        end
        I2F_ABS: begin
          sign <= operand[INT_W-1];
          mag  <= mag_abs;
          exp  <= EXP_MAX;
          if (mag_abs == 32'd0) begin
            data_out   <= 32'd0;
            status_out <= status_word(1'b0);
            done       <= 1'b1;
            state      <= I2F_READY;
          end else begin
            state      <= I2F_NORM;
          end
        end
        I2F_NORM: begin
          if (!mag[INT_W-1]) begin
            mag <= {mag[INT_W-2:0], 1'b0};
            exp <= exp - 7'd1;
          end else begin
            state <= I2F_ROUND;
          end
        end
        I2F_ROUND: begin
          // Exponent never exceeds EXP_MAX, even after a rounding carry.
          data_out   <= fp_pack(sign, exp + {6'd0, carry}, frac_rnd);
          status_out <= status_word(inexact);
          exp        <= exp + {6'd0, carry};
          done       <= 1'b1;
          state      <= I2F_READY;
        end
        I2F_READY: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= I2F_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= I2F_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp.sv
// Scoreboard bench for int_to_fp: the driver queues expected results, a
// negedge monitor pops and compares them whenever done is seen.
module tb_int_to_fp;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] int_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int_to_fp dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .int_in     (int_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  st;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] in;
    logic [31:0] data;
    logic [3:0]  st;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got data %h expected no done", data_out);
      end else begin
        e = sb.pop_front();
        chk("data_out", data_out, e.data);
        chk("status_out", {28'd0, status_out}, {28'd0, e.st});
        chk("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic issue(input logic [31:0] v, input logic [31:0] d, input logic [3:0] s, input int lat);
    @(negedge clk);
    sb.push_back('{d, s, cyc + 1 + lat});
    start  = 1'b1;
    int_in = v;
    @(negedge clk);
    start  = 1'b0;
    int_in = 32'h5A5A_5A5A;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      $display("FAIL %s_timeout: got no done expected done within 60 cycles", nm);
    end
  endtask

  vec_t vecs[8] = '{
    '{32'h0000_0001, 32'h3F00_0000, 4'b0001, 34},
    '{32'hFFFF_FFFF, 32'hBF00_0000, 4'b0001, 34},
    '{32'h0000_0003, 32'h4080_0000, 4'b0001, 33},
    '{32'h8000_0000, 32'hDE00_0000, 4'b0001, 3},
    '{32'h7FFF_FFFF, 32'h5E00_0000, 4'b1000, 4},
    '{32'h0200_0001, 32'h5800_0000, 4'b1000, 9},
    '{32'h0200_0003, 32'h5800_0002, 4'b1000, 9},
    '{32'h0000_0000, 32'h0000_0000, 4'b0001, 1}
  };

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int s;
    reset  = 1'b0;
    start  = 1'b0;
    int_in = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_status", {28'd0, status_out}, 32'd0);
    reset = 1'b1;

    // Directed conversions, including rounding carry and ties.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].in, vecs[i].data, vecs[i].st, vecs[i].lat);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      wait_done("vec");
      @(negedge clk);
      chk("done_pulse_low", {31'd0, done}, 32'd0);
      chk("data_hold", data_out, vecs[i].data);
    end

    // Start while busy is ignored: 5 -> 0x41400000, k=29.
    issue(32'h0000_0005, 32'h4140_0000, 4'b0001, 32);
    repeat (3) @(negedge clk);
    start  = 1'b1;
    int_in = 32'h8000_0000;
    @(negedge clk);
    start  = 1'b0;
    wait_done("ignore");
    repeat (10) @(negedge clk);
    chk("ignore_idle_busy", {31'd0, busy}, 32'd0);

    // Reset mid-normalisation clears everything and suppresses done.
    issue(32'h0000_0001, 32'h3F00_0000, 4'b0001, 34);
    repeat (5) @(negedge clk);
    chk("norm_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_data", data_out, 32'd0);
    chk("abort_status", {28'd0, status_out}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_restart", {31'd0, busy}, 32'd0);

    // Start raised in the done cycle is accepted one cycle later.
    issue(32'h0000_0003, 32'h4080_0000, 4'b0001, 33);
    wait_done("b2b_first");
    s = cyc;
    sb.push_back('{32'hDE00_0000, 4'b0001, s + 2 + 3});
    start  = 1'b1;
    int_in = 32'h8000_0000;
    @(negedge clk);
    @(negedge clk);
    start  = 1'b0;
    wait_done("b2b_second");
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
